// File: rtl/mc_controller_p_if.sv
// Control bundle between the multicycle controller and the datapath: decode
// inputs (op/funct/zero/mem_ready) and all datapath control outputs.
interface mc_controller_p_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned BEATS = 32 / DATA_WIDTH;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             memread;
  logic             memwrite;
  logic             alusrca;
  logic             memtoreg;
  logic             iord;
  logic             pcen;
  logic             regwrite;
  logic             regdst;
  logic [1:0]       pcsrc;
  logic [1:0]       alusrcb;
  logic [2:0]       alucontrol;
  logic [BEATS-1:0] irwrite;
  logic             illegal_op;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsrc, alusrcb, alucontrol, irwrite, illegal_op
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsrc, alusrcb, alucontrol, irwrite, illegal_op
  );
endinterface

// File: rtl/mc_controller_p.sv
// Multicycle MIPS controller with 1/2/4-beat instruction fetch, memory-ready
// handshake, ADDI/J and illegal-opcode flag. Optional BNE via `MC_BNE_EN.
module mc_controller_p #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  mc_controller_p_if.master bus
);
  localparam int unsigned BEATS  = 32 / DATA_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("mc_controller_p: DATA_WIDTH must be 8, 16 or 32");
  end

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
`ifdef MC_BNE_EN
    , S_BNEEX
`endif
  } state_t;

  state_t            r_state;
  logic [BEAT_W-1:0] r_beat;
  logic              r_store;

  state_t            w_dec_next;
  logic              w_dec_illegal;
  logic              w_funct_ok;
  logic [2:0]        w_alu_rtype;

  // Opcode / funct decode used in DECODE and RTYPEEX
  always_comb begin
    w_funct_ok  = 1'b1;
    w_alu_rtype = 3'b010;
    case (bus.funct)
      6'h20:   w_alu_rtype = 3'b010;
      6'h22:   w_alu_rtype = 3'b110;
      6'h24:   w_alu_rtype = 3'b000;
      6'h25:   w_alu_rtype = 3'b001;
      6'h2a:   w_alu_rtype = 3'b111;
      default: w_funct_ok  = 1'b0;
    endcase

    w_dec_next    = S_FETCH;
    w_dec_illegal = 1'b0;
    case (bus.op)
      6'h20, 6'h28: w_dec_next = S_MEMADR;
      6'h00: begin
        if (w_funct_ok) w_dec_next    = S_RTYPEEX;
        else            w_dec_illegal = 1'b1;
      end
      6'h04: w_dec_next = S_BEQEX;
      6'h08: w_dec_next = S_ADDIEX;
      6'h02: w_dec_next = S_JEX;
`ifdef MC_BNE_EN
      6'h05: w_dec_next = S_BNEEX;
`endif
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // State and fetch-beat register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_beat  <= '0;
      r_store <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            if (r_beat == BEAT_W'(BEATS - 1)) begin
              r_beat  <= '0;
              r_state <= S_DECODE;
            end else begin
              r_beat  <= r_beat + 1'b1;
            end
          end
        end
        S_DECODE: begin
          r_state <= w_dec_next;
          r_store <= (bus.op == 6'h28);
        end
        S_MEMADR:  r_state <= r_store ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   if (bus.mem_ready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_RTYPEWB: r_state <= S_FETCH;
        S_BEQEX:   r_state <= S_FETCH;
        S_ADDIEX:  r_state <= S_ADDIWB;
        S_ADDIWB:  r_state <= S_FETCH;
        S_JEX:     r_state <= S_FETCH;
`ifdef MC_BNE_EN
        S_BNEEX:   r_state <= S_FETCH;
`endif
        default: begin
          r_state <= S_FETCH;
          r_beat  <= '0;
        end
      endcase
    end
  end

  logic             w_memread, w_memwrite, w_alusrca, w_memtoreg, w_iord;
  logic             w_regwrite, w_regdst, w_pcwrite, w_branch, w_branch_ne;
  logic             w_illegal;
  logic [1:0]       w_pcsrc, w_alusrcb;
  logic [2:0]       w_alucontrol;
  logic [BEATS-1:0] w_irwrite;

  // Moore decode of state; IR/PC writes in FETCH wait for mem_ready
  always_comb begin
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_alusrca    = 1'b0;
    w_memtoreg   = 1'b0;
    w_iord       = 1'b0;
    w_regwrite   = 1'b0;
    w_regdst     = 1'b0;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_branch_ne  = 1'b0;
    w_illegal    = 1'b0;
    w_pcsrc      = 2'b00;
    w_alusrcb    = 2'b00;
    w_alucontrol = 3'b010;
    w_irwrite    = '0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        if (bus.mem_ready) begin
          w_irwrite = BEATS'(1'b1) << r_beat;
          w_pcwrite = 1'b1;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        w_illegal = w_dec_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      S_RTYPEEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = w_alu_rtype;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = 3'b110;
        w_pcsrc      = 2'b01;
        w_branch     = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        w_alusrca    = 1'b1;
        w_alucontrol = 3'b110;
        w_pcsrc      = 2'b01;
        w_branch_ne  = 1'b1;
      end
`endif
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Everything is forced low while reset is held
  assign bus.memread    = reset & w_memread;
  assign bus.memwrite   = reset & w_memwrite;
  assign bus.alusrca    = reset & w_alusrca;
  assign bus.memtoreg   = reset & w_memtoreg;
  assign bus.iord       = reset & w_iord;
  assign bus.regwrite   = reset & w_regwrite;
  assign bus.regdst     = reset & w_regdst;
  assign bus.illegal_op = reset & w_illegal;
  assign bus.pcen       = reset & (w_pcwrite | (w_branch & bus.zero) | (w_branch_ne & ~bus.zero));
  assign bus.pcsrc      = reset ? w_pcsrc      : '0;
  assign bus.alusrcb    = reset ? w_alusrcb    : '0;
  assign bus.alucontrol = reset ? w_alucontrol : '0;
  assign bus.irwrite    = reset ? w_irwrite    : '0;
endmodule

// File: tb/tb_mc_controller_p.sv
// Self-checking bench for mc_controller_p: instruction-level expected cycle
// streams are built from the instruction rules and compared every cycle.
module tb_mc_controller_p;
  localparam int unsigned DW    = 8;
  localparam int unsigned BEATS = 32 / DW;

  logic clk;
  logic reset;

  mc_controller_p_if #(.DATA_WIDTH(DW)) bus();
  mc_controller_p #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             memread;
    logic             memwrite;
    logic             alusrca;
    logic             memtoreg;
    logic             iord;
    logic             pcen;
    logic             regwrite;
    logic             regdst;
    logic [1:0]       pcsrc;
    logic [1:0]       alusrcb;
    logic [2:0]       alucontrol;
    logic             illegal_op;
    logic [BEATS-1:0] irwrite;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] funct;
    outs_t      exp;
    outs_t      care;
  } cyc_t;

  cyc_t       q[$];
  logic [5:0] cur_op;
  logic [5:0] cur_funct;
  int         n_vec;
  int         n_err;
  outs_t      act;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h20, 6'h28, 6'h04, 6'h08, 6'h02: return 1'b1;
      6'h00: return (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
`ifdef MC_BNE_EN
      6'h05: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Strobes and write enables are always checked; mux selects only where defined
  function automatic outs_t strobe_care();
    outs_t c;
    c = '0;
    c.memread    = 1'b1;
    c.memwrite   = 1'b1;
    c.pcen       = 1'b1;
    c.regwrite   = 1'b1;
    c.illegal_op = 1'b1;
    c.irwrite    = '1;
    return c;
  endfunction

  task automatic push(input logic mr, input logic z, input outs_t e, input outs_t c);
    cyc_t r;
    r.rst = 1'b1; r.mr = mr; r.z = z; r.op = cur_op; r.funct = cur_funct;
    r.exp = e; r.care = c;
    q.push_back(r);
  endtask

  task automatic push_reset(input int n, input logic mr);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r.rst = 1'b0; r.mr = mr; r.z = rbit(); r.op = cur_op; r.funct = cur_funct;
      r.exp = '0; r.care = '1;
      q.push_back(r);
    end
  endtask

  task automatic fetch_rec(input int b, input logic rdy);
    outs_t e, c;
    logic [BEATS-1:0] one;
    one = 1;
    e = '0; c = strobe_care();
    c.alusrca = 1'b1; c.iord = 1'b1; c.alusrcb = '1; c.alucontrol = '1; c.pcsrc = '1;
    e.memread = 1'b1; e.alusrcb = 2'b01; e.alucontrol = 3'b010;
    e.pcen    = rdy;
    e.irwrite = rdy ? (one << b) : '0;
    push(rdy, rbit(), e, c);
  endtask

  // Expected cycle stream of one instruction, fetch through writeback.
  // fb/fn: stall fn cycles before fetch beat fb; mn: memory-access stalls;
  // bz: zero flag in the branch cycle (0/1, or 2 for random).
  task automatic gen_instr(input logic [5:0] o, input logic [5:0] f,
                           input int fb, input int fn, input int mn, input int bz);
    outs_t e, c;
    logic  z;
    cur_op = o; cur_funct = f;
    for (int b = 0; b < BEATS; b++) begin
      for (int s = 0; s < ((b == fb) ? fn : 0); s++) fetch_rec(b, 1'b0);
      fetch_rec(b, 1'b1);
    end
    e = '0; c = strobe_care();
    c.alusrca = 1'b1; c.alusrcb = '1; c.alucontrol = '1;
    e.alusrcb = 2'b11; e.alucontrol = 3'b010; e.illegal_op = ~legal(o, f);
    push(rbit(), rbit(), e, c);
    if (!legal(o, f)) return;
    e = '0; c = strobe_care();
    c.alusrca = 1'b1; c.alusrcb = '1; c.alucontrol = '1;
    case (o)
      6'h20, 6'h28: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
        push(rbit(), rbit(), e, c);
        e = '0; c = strobe_care(); c.iord = 1'b1; e.iord = 1'b1;
        if (o == 6'h20) e.memread = 1'b1; else e.memwrite = 1'b1;
        for (int s = 0; s < mn; s++) push(1'b0, rbit(), e, c);
        push(1'b1, rbit(), e, c);
        if (o == 6'h20) begin
          e = '0; c = strobe_care(); c.memtoreg = 1'b1; c.regdst = 1'b1;
          e.regwrite = 1'b1; e.memtoreg = 1'b1;
          push(rbit(), rbit(), e, c);
        end
      end
      6'h00: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b00; e.alucontrol = alu_of(f);
        push(rbit(), rbit(), e, c);
        e = '0; c = strobe_care(); c.memtoreg = 1'b1; c.regdst = 1'b1;
        e.regwrite = 1'b1; e.regdst = 1'b1;
        push(rbit(), rbit(), e, c);
      end
      6'h04, 6'h05: begin
        z = (bz > 1) ? rbit() : bz[0];
        c.pcsrc = '1;
        e.alusrca = 1'b1; e.alusrcb = 2'b00; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (o == 6'h04) ? z : ~z;
        push(rbit(), z, e, c);
      end
      6'h08: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
        push(rbit(), rbit(), e, c);
        e = '0; c = strobe_care(); c.memtoreg = 1'b1; c.regdst = 1'b1;
        e.regwrite = 1'b1;
        push(rbit(), rbit(), e, c);
      end
      default: begin
        c = strobe_care(); c.pcsrc = '1;
        e.pcsrc = 2'b10; e.pcen = 1'b1;
        push(rbit(), rbit(), e, c);
      end
    endcase
  endtask

  task automatic step(input cyc_t r, output outs_t a);
    @(negedge clk);
    reset = r.rst; bus.mem_ready = r.mr; bus.zero = r.z;
    bus.op = r.op; bus.funct = r.funct;
    #1;
    a.memread = bus.memread;   a.memwrite = bus.memwrite; a.alusrca = bus.alusrca;
    a.memtoreg = bus.memtoreg; a.iord = bus.iord;         a.pcen = bus.pcen;
    a.regwrite = bus.regwrite; a.regdst = bus.regdst;     a.pcsrc = bus.pcsrc;
    a.alusrcb = bus.alusrcb;   a.alucontrol = bus.alucontrol;
    a.illegal_op = bus.illegal_op; a.irwrite = bus.irwrite;
  endtask

  task automatic test_reset();
    q.delete();
    cur_op = 6'h00; cur_funct = 6'h20;
    push_reset(2, 1'b1);
    fetch_rec(0, 1'b1);
    fetch_rec(1, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL reset cyc%0d act=%h exp=%h care=%h", i, act, q[i].exp, q[i].care);
      end
    end
  endtask

  task automatic test_lb();
    q.delete();
    push_reset(2, 1'b0);
    gen_instr(6'h20, 6'h3f, -1, 0, 0, 2);
    fetch_rec(0, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL lb cyc%0d act=%h exp=%h care=%h", i, act, q[i].exp, q[i].care);
      end
    end
  endtask

  task automatic test_rtype();
    q.delete();
    push_reset(2, 1'b0);
    gen_instr(6'h00, 6'h22, -1, 0, 0, 2);
    gen_instr(6'h00, 6'h3f, -1, 0, 0, 2);
    gen_instr(6'h00, 6'h20, -1, 0, 0, 2);
    gen_instr(6'h00, 6'h24, -1, 0, 0, 2);
    gen_instr(6'h00, 6'h25, -1, 0, 0, 2);
    gen_instr(6'h00, 6'h2a, -1, 0, 0, 2);
    fetch_rec(0, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL rtype cyc%0d act=%h exp=%h care=%h", i, act, q[i].exp, q[i].care);
      end
    end
  endtask

  task automatic test_branch();
    q.delete();
    push_reset(2, 1'b0);
    gen_instr(6'h04, 6'h00, -1, 0, 0, 1);
    gen_instr(6'h04, 6'h00, -1, 0, 0, 0);
    gen_instr(6'h05, 6'h00, -1, 0, 0, 0);
    gen_instr(6'h05, 6'h00, -1, 0, 0, 1);
    gen_instr(6'h02, 6'h00, -1, 0, 0, 2);
    fetch_rec(0, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL branch cyc%0d act=%h exp=%h care=%h", i, act, q[i].exp, q[i].care);
      end
    end
  endtask

  task automatic test_stall();
    q.delete();
    push_reset(2, 1'b0);
    gen_instr(6'h08, 6'h00, 2, 3, 0, 2);
    gen_instr(6'h20, 6'h00, 0, 1, 2, 2);
    gen_instr(6'h28, 6'h00, 3, 2, 3, 2);
    fetch_rec(0, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL stall cyc%0d act=%h exp=%h care=%h", i, act, q[i].exp, q[i].care);
      end
    end
  endtask

  task automatic test_abort();
    q.delete();
    push_reset(2, 1'b0);
    gen_instr(6'h20, 6'h00, -1, 0, 0, 2);
    void'(q.pop_back());
    void'(q.pop_back());
    push_reset(2, 1'b1);
    fetch_rec(0, 1'b1);
    fetch_rec(1, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL abort cyc%0d act=%h exp=%h care=%h", i, act, q[i].exp, q[i].care);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    ops = '{6'h20, 6'h28, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    q.delete();
    push_reset(2, 1'b0);
    for (int n = 0; n < 60; n++) begin
      o = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      f = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) f = 6'($urandom);
      gen_instr(o, f, $urandom_range(0, BEATS - 1), $urandom_range(0, 2),
                $urandom_range(0, 2), 2);
    end
    fetch_rec(0, 1'b0);
    foreach (q[i]) begin
      step(q[i], act); n_vec++;
      if ((act & q[i].care) !== (q[i].exp & q[i].care)) begin
        n_err++;
        $display("FAIL random cyc%0d op=%h funct=%h act=%h exp=%h care=%h",
                 i, q[i].op, q[i].funct, act, q[i].exp, q[i].care);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_lb();
    test_rtype();
    test_branch();
    test_stall();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mc_controller_p.md
Name: mc_controller_p

Overview:
- Parametrised successor to the multicycle MIPS `controller`.
- Drives the multicycle datapath's control signals from op/funct/zero.
- Instruction fetch is generalised to 1, 2 or 4 beats depending on datapath width.
- Adds a memory-ready handshake, ADDI/J support and an illegal-opcode flag. Sits between instruction register decode and the datapath muxes/enables.

Parameters:
- DATA_WIDTH, 8, datapath/memory width in bits. Legal values 8, 16, 32; any other value is a synthesis error.
- BEATS (localparam), 32/DATA_WIDTH, fetch beats per instruction. Width of irwrite.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- op  in  6  instruction opcode
- funct  in  6  R-type function field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0=PC, 1=register A
- memtoreg  out  1  register write data from memory
- iord  out  1  0=PC address, 1=ALUOut address
- pcen  out  1  PC write enable
- regwrite  out  1  register file write
- regdst  out  1  0=rt, 1=rd
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target
- alusrcb  out  2  00 B, 01 increment constant, 10 signext imm, 11 shifted imm
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- irwrite  out  BEATS  one-hot IR byte-lane write enable
- illegal_op  out  1  pulse: undecodable op/funct seen in DECODE

Behaviour:
- Reset:
  - While reset==0, every output is forced to 0, combinationally gated.
  - On a clk edge with reset==0, the state goes to FETCH and the beat counter to 0.
  - Reset mid-instruction aborts it with no further writes.
- Outputs are a Moore decode of the state and beat counter, except:
  - pcen = pcwrite | (branch & zero)
  - memory strobes qualified as below.
- FETCH:
  - Drives memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite[beat] and pcwrite are asserted only in cycles with mem_ready=1.
  - Beat advances on mem_ready. After beat BEATS-1 completes, go to DECODE.
  - With mem_ready=0, hold with no IR/PC writes.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010. Next state by op:
  - 6'h20 LB -> MEMADR
  - 6'h28 SB -> MEMADR
  - 6'h00 R-type -> RTYPEEX
  - 6'h04 BEQ -> BEQEX
  - 6'h08 ADDI -> ADDIEX
  - 6'h02 J -> JEX
  - otherwise -> FETCH, with illegal_op=1 for that cycle
  - R-type with an unknown funct also sets illegal_op and returns to FETCH.
- MEMADR: alusrca=1, alusrcb=10, alu add. Next is MEMRD (LB) or MEMWR (SB).
- MEMRD: memread=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEMWR: memwrite=1, iord=1. Hold until mem_ready, then FETCH.
  - memwrite stays asserted for every cycle spent in MEMWR.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct:
  - 20 -> 010, 22 -> 110, 24 -> 000, 25 -> 001, 2a -> 111
  - Then RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Then ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- JEX: pcsrc=10, pcwrite=1. Then FETCH.
- Latency with mem_ready tied 1 and BEATS=4:
  - R-type 7 cycles
  - LB 8
  - SB 7
  - BEQ 6
  - ADDI 7
  - J 6
- Each mem_ready=0 cycle in a memory state adds exactly one cycle.
- Unused state encodings recover to FETCH beat 0 on the next edge.

Optional Feature:
- MC_BNE_EN
  - Defined: op 6'h05 (BNE) -> BNEEX, same as BEQEX except pcen = branch & ~zero.
  - Undefined: op 6'h05 is illegal (illegal_op pulse, return to FETCH).

Test Plan:
- Reset: hold reset=0 two edges, release -> all outputs 0 during reset; first cycle after shows memread=1, irwrite=4'b0001, pcen=1.
- LB: op=6'h20, mem_ready=1 -> irwrite walks 0001/0010/0100/1000, DECODE, MEMADR, MEMRD, then MEMWB with regwrite=1 and memtoreg=1; back in FETCH at cycle 9.
- R-type: op=0, funct=6'h22 -> RTYPEEX alucontrol=110, RTYPEWB regwrite=1 and regdst=1; funct=6'h3f -> illegal_op pulse, no regwrite.
- BEQ: op=6'h04 with zero=1 -> pcen=1, pcsrc=01 in BEQEX; with zero=0 -> pcen=0.
- Stall: mem_ready=0 for 3 cycles during fetch beat 2 -> irwrite=0 and pcen=0 while stalled; irwrite=0100 on release; instruction latency +3.
- BNE: op=6'h05, zero=0 -> pcen=1 with MC_BNE_EN; illegal_op=1 without it.
